seg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display-value selector and consumes its 32-bit `num` word. It renders `num` as eight hex digits or, via an iterative binary-to-BCD converter, as up to eight decimal digits. It scans the digits with a programmable refresh prescaler and optionally blanks leading zeros.

---
 rtl/seg_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit common-anode seven-segment scan driver.
// A free-running converter snapshots num/dec_mode, optionally converts to
// BCD by double-dabble, and publishes an 8-nibble display word. A refresh
// prescaler walks the digit index; the output register drives one digit per
// index with optional leading-zero blanking and an overflow dash pattern.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_LOAD  | snapshot num/dec_mode, clear BCD accumulator
// S_SHIFT | 32 double-dabble steps, one input bit per cycle, MSB first
// S_DONE  | publish display word and overflow flag
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] num,
  input  logic        dec_mode,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_shadow;
  logic          r_dec;
  logic [31:0]   r_sr;
  logic [39:0]   r_bcd;
  logic [4:0]    r_bit_cnt;
  logic [31:0]   r_disp_q;
  logic          r_ovf;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;

  logic [39:0]   w_bcd_adj;
  logic [7:0]    w_upper_zero;
  logic [3:0]    w_nib;
  logic          w_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every BCD nibble before the next shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM: LOAD -> SHIFT x32 -> DONE -> LOAD, bit count runs down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_shadow  <= '0;
      r_dec     <= 1'b0;
      r_sr      <= '0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
      r_disp_q  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_shadow  <= num;
          r_dec     <= dec_mode;
          r_sr      <= num;
          r_bcd     <= '0;
          r_bit_cnt <= 5'd31;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_bcd, r_sr} <= {w_bcd_adj, r_sr} << 1;
          r_bit_cnt     <= r_bit_cnt - 5'd1;
          if (r_bit_cnt == 5'd0)
            r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_dec) begin
            r_disp_q <= r_bcd[31:0];
            r_ovf    <= |r_bcd[39:32];
          end else begin
            r_disp_q <= r_shadow;
            r_ovf    <= 1'b0;
          end
          r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Refresh prescaler: advance the digit index once every REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_TC) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Leading-zero detection: digit i may blank when nibbles i..7 are all zero.
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < 8; i++)
      w_upper_zero[i] = ((r_disp_q >> (4*i)) == 32'd0);
    w_nib   = r_disp_q[{r_idx, 2'b00} +: 4];
    w_blank = blank_lz & ~r_ovf & (r_idx != 3'd0) & w_upper_zero[r_idx];
  end

  // Output register: one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else if (w_blank) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      an  <= ~(8'd1 << r_idx);
      seg <= r_ovf ? 7'h3F : decode(w_nib);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: per-cycle expected outputs are pushed by the
// stimulus side from an arithmetic display model and popped by a monitor.
module tb_seg_scan_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] num = '0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .reset    (reset),
    .num      (num),
    .dec_mode (dec_mode),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct {
    logic [31:0] v;
    bit          dec;
    int          vis;
  } conv_t;

  exp_t  exp_q[$];
  conv_t pend[$];

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [31:0] cur_v = '0;
  bit          cur_dec = 1'b0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic longint pow10(input int k);
    longint p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return p;
  endfunction

  // Display model: what digit idx should show for value v in the given mode.
  function automatic exp_t model_out(input int idx, input logic [31:0] v,
                                     input bit dec, input bit blk);
    exp_t   e;
    bit     ovf;
    bit     sig;
    int     d;
    longint lv;
    lv  = {32'd0, v};
    ovf = dec && (lv > 64'd99_999_999);
    if (dec) begin
      d   = int'((lv / pow10(idx)) % 10);
      sig = (lv >= pow10(idx));
    end else begin
      d   = int'((v >> (4*idx)) & 32'hF);
      sig = ((v >> (4*idx)) != 32'd0);
    end
    if (blk && !ovf && idx != 0 && !sig) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end else begin
      e.an  = ~(8'd1 << idx);
      e.seg = ovf ? 7'h3F : seg_tbl[d];
    end
    return e;
  endfunction

  // Advance one clock edge and push the output expected right after it.
  task automatic step();
    exp_t  e;
    conv_t c;
    @(posedge clk);
    #1;
    if (reset) begin
      n = 0;
      pend.delete();
      cur_v   = '0;
      cur_dec = 1'b0;
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end else begin
      n++;
      if (n % 34 == 1) begin
        c.v   = num;
        c.dec = dec_mode;
        c.vis = n + 34;
        pend.push_back(c);
      end
      if (pend.size() > 0 && pend[0].vis == n) begin
        c = pend.pop_front();
        cur_v   = c.v;
        cur_dec = c.dec;
      end
      e = model_out(((n - 1) / RD) % 8, cur_v, cur_dec, blank_lz);
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic scenario(input logic [31:0] v, input bit dm, input bit bl, input int k);
    num      = v;
    dec_mode = dm;
    blank_lz = bl;
    run(k);
  endtask

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== 1'b1) begin
        errors++;
        $display("FAIL scan n=%0d num=%h dec=%b blank=%b: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
                 n, num, dec_mode, blank_lz, an, seg, dp, e.an, e.seg);
      end
    end
  end

  initial begin
    int cat;
    logic [31:0] v;
    reset = 1'b1;
    run(3);
    reset = 1'b0;

    scenario(32'd0,           1'b0, 1'b0, 110);
    scenario(32'h0000_1A2F,   1'b0, 1'b0, 110);
    scenario(32'd12345,       1'b1, 1'b1, 110);
    scenario(32'd0,           1'b1, 1'b1, 110);
    scenario(32'd99_999_999,  1'b1, 1'b0, 110);
    scenario(32'd100_000_000, 1'b1, 1'b1, 110);

    // num changes two cycles after a LOAD
    scenario(32'd5, 1'b1, 1'b0, 80);
    for (int j = 0; j < 40 && (n % 34) != 3; j++) step();
    num = 32'd7;
    run(110);

    // reset lands on SHIFT cycle 10 of a conversion
    scenario(32'hDEAD_BEEF, 1'b0, 1'b0, 80);
    for (int j = 0; j < 40 && (n % 34) != 10; j++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(110);

    // dec_mode toggled mid-conversion
    scenario(32'd4321, 1'b1, 1'b1, 80);
    for (int j = 0; j < 40 && (n % 34) != 15; j++) step();
    dec_mode = 1'b0;
    run(110);

    for (int it = 0; it < 40; it++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        2: v = 32'd99_999_990 + $urandom_range(0, 20);
        default: v = 32'h1 << (4 * $urandom_range(0, 7));
      endcase
      scenario(v, 1'($urandom % 2), 1'($urandom % 2), $urandom_range(20, 70));
      blank_lz = ~blank_lz;
      run($urandom_range(20, 60));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
